plugin_chunk_adder: RTL and testbench

//  Multi-cycle adder engine behind the memory-mapped plugin register window (OPA/OPB/RES/CTRL).

---
 rtl/plugin_chunk_adder.sv | 126 ++++++++++++
 tb/tb_plugin_chunk_adder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/plugin_chunk_adder.sv
// Multi-cycle adder behind the plugin register window: adds two DATA_WIDTH operands
// one CHUNK_WIDTH slice per cycle (LSB first) through a registered carry.
module plugin_chunk_adder #(
  parameter int DATA_WIDTH  = 32,
  parameter int CHUNK_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] operand_a,
  input  logic [DATA_WIDTH-1:0] operand_b,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  busy,
  output logic                  done,
  output logic                  carry_out,
  output logic                  overflow,
  output logic                  state_dbg
);

  // Handshake: start is a one-cycle pulse, accepted only when the engine is idle (busy=0);
  // operands are sampled on that edge. busy stays high for exactly NCHUNK cycles, then result,
  // carry_out and overflow update together and done is set. done stays set until the next accept.
  // A start seen while busy is dropped without effect.

  localparam int NCHUNK = DATA_WIDTH / CHUNK_WIDTH;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

  generate
    if (CHUNK_WIDTH < 1 || (DATA_WIDTH % CHUNK_WIDTH) != 0) begin : g_bad_chunk
      $error("plugin_chunk_adder: CHUNK_WIDTH must divide DATA_WIDTH");
    end
  endgenerate

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state, state_next;

  logic [DATA_WIDTH-1:0]  op_a, op_b, shadow;
  logic [CNT_W-1:0]       cnt;
  logic                   carry;

  logic                   accept, last;
  logic [31:0]            shamt;
  logic [CHUNK_WIDTH-1:0] a_i, b_i;
  logic [CHUNK_WIDTH:0]   slice_sum;
  logic [DATA_WIDTH-1:0]  s_ext, mask_ext, shadow_upd;
  logic                   msb_carry_in;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: begin
        accept = start;
        if (start) state_next = RUN;
      end
      RUN: begin
        last = (cnt == LAST_CNT);
        if (last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Current slice, selected by shifting so the slice index never needs a wide part-select.
  always_comb begin
    shamt     = 32'(cnt) * 32'(CHUNK_WIDTH);
    a_i       = CHUNK_WIDTH'(op_a >> shamt);
    b_i       = CHUNK_WIDTH'(op_b >> shamt);
    slice_sum = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK_WIDTH{1'b0}}, carry};
    s_ext     = '0;
    s_ext[CHUNK_WIDTH-1:0] = slice_sum[CHUNK_WIDTH-1:0];
    mask_ext  = '0;
    mask_ext[CHUNK_WIDTH-1:0] = '1;
    shadow_upd = (shadow & ~(mask_ext << shamt)) | (s_ext << shamt);
    // On the last slice, sum MSB = a ^ b ^ carry-in, so the carry into the MSB falls out directly.
    msb_carry_in = op_a[DATA_WIDTH-1] ^ op_b[DATA_WIDTH-1] ^ slice_sum[CHUNK_WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_a      <= '0;
      op_b      <= '0;
      shadow    <= '0;
      cnt       <= '0;
      carry     <= 1'b0;
      result    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else if (accept) begin
      op_a   <= operand_a;
      op_b   <= operand_b;
      shadow <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      busy   <= 1'b1;
      done   <= 1'b0;
    end else if (state == RUN) begin
      shadow <= shadow_upd;
      carry  <= slice_sum[CHUNK_WIDTH];
      cnt    <= cnt + 1'b1;
      if (last) begin
        result    <= shadow_upd;
        carry_out <= slice_sum[CHUNK_WIDTH];
        overflow  <= msb_carry_in ^ slice_sum[CHUNK_WIDTH];
        busy      <= 1'b0;
        done      <= 1'b1;
      end
    end
  end

  assign state_dbg = (state == RUN);

endmodule

// File: tb/tb_plugin_chunk_adder.sv
// Bench for plugin_chunk_adder: directed operations on an 8-bit-chunk and a full-width instance,
// expected {carry_out, overflow, result} queued at issue and checked when done rises.
module tb_plugin_chunk_adder;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start0, start1;
  logic [DW-1:0] a0, b0, a1, b1;
  logic [DW-1:0] result0, result1;
  logic          busy0, done0, cout0, ovf0, st0;
  logic          busy1, done1, cout1, ovf1, st1;

  logic [DW+1:0] exp_q0[$];
  logic [DW+1:0] exp_q1[$];

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  plugin_chunk_adder #(.DATA_WIDTH(DW), .CHUNK_WIDTH(8)) u_dut0 (
    .clk(clk), .reset(reset), .start(start0), .operand_a(a0), .operand_b(b0),
    .result(result0), .busy(busy0), .done(done0), .carry_out(cout0), .overflow(ovf0),
    .state_dbg(st0)
  );

  plugin_chunk_adder #(.DATA_WIDTH(DW), .CHUNK_WIDTH(32)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .operand_a(a1), .operand_b(b1),
    .result(result1), .busy(busy1), .done(done1), .carry_out(cout1), .overflow(ovf1),
    .state_dbg(st1)
  );

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // ---------------- monitors ----------------
  int  streak0 = 0, streak1 = 0;
  logic done0_q = 1'b0, done1_q = 1'b0;

  always @(negedge clk) begin
    logic [DW+1:0] e;
    if (done0 && !done0_q) begin
      check("dut0_busy_cycles", 64'(streak0), 64'd4);
      if (exp_q0.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL dut0_unexpected_done: got result 0x%0h expected no completion", result0);
      end else begin
        e = exp_q0.pop_front();
        check("dut0_result", 64'(result0), 64'(e[DW-1:0]));
        check("dut0_carry_out", 64'(cout0), 64'(e[DW+1]));
        check("dut0_overflow", 64'(ovf0), 64'(e[DW]));
      end
    end
    if (busy0) streak0++;
    else       streak0 = 0;
    done0_q = done0;
  end

  always @(negedge clk) begin
    logic [DW+1:0] e;
    if (done1 && !done1_q) begin
      check("dut1_busy_cycles", 64'(streak1), 64'd1);
      if (exp_q1.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL dut1_unexpected_done: got result 0x%0h expected no completion", result1);
      end else begin
        e = exp_q1.pop_front();
        check("dut1_result", 64'(result1), 64'(e[DW-1:0]));
        check("dut1_carry_out", 64'(cout1), 64'(e[DW+1]));
        check("dut1_overflow", 64'(ovf1), 64'(e[DW]));
      end
    end
    if (busy1) streak1++;
    else       streak1 = 0;
    done1_q = done1;
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; start is sampled on the next edge.
  task automatic issue(input int which, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [DW-1:0] exp_res, input logic exp_c, input logic exp_v,
                       input bit push);
    if (which == 0) begin
      a0 = a; b0 = b; start0 = 1'b1;
      if (push) exp_q0.push_back({exp_c, exp_v, exp_res});
    end else begin
      a1 = a; b1 = b; start1 = 1'b1;
      if (push) exp_q1.push_back({exp_c, exp_v, exp_res});
    end
    @(posedge clk); #1;
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait_done(input int which);
    int t = 0;
    while (t < 20 && !((which == 0) ? (done0 && !busy0) : (done1 && !busy1))) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) begin
      n_cmp++; n_fail++;
      $display("FAIL wait_done%0d: got timeout expected completion within 20 cycles", which);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; start0 = 1'b0; start1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_result0", 64'(result0), 64'd0);
    check("rst_busy0", 64'(busy0), 64'd0);
    check("rst_done0", 64'(done0), 64'd0);
    check("rst_flags0", 64'({cout0, ovf0, st0}), 64'd0);
    check("rst_result1", 64'(result1), 64'd0);
    check("rst_flags1", 64'({busy1, done1, cout1, ovf1, st1}), 64'd0);
    @(posedge clk); #1;

    // cross-slice carry
    issue(0, 32'h000000FF, 32'h00000001, 32'h00000100, 1'b0, 1'b0, 1'b1);
    wait_done(0);
    // carry out of the MSB, then signed overflow
    issue(0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1);
    wait_done(0);
    issue(0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b1);
    wait_done(0);

    // start and operand change during RUN are ignored
    issue(0, 32'h12345678, 32'h11111111, 32'h23456789, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    start0 = 1'b1; a0 = 32'hFFFFFFFF; b0 = 32'hFFFFFFFF;
    @(posedge clk); #1;
    start0 = 1'b0;
    check("run_busy_after_ignored_start", 64'(busy0), 64'd1);
    wait_done(0);
    check("idle_state_dbg", 64'(st0), 64'd0);

    // result holds the previous value during RUN; done drops at accept
    issue(0, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("run_result_hold", 64'(result0), 64'h23456789);
      check("run_done_low", 64'(done0), 64'd0);
      check("run_busy_high", 64'(busy0), 64'd1);
    end
    wait_done(0);

    // reset on the second RUN cycle aborts the run
    issue(0, 32'h0000FFFF, 32'h0000FFFF, 32'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_result", 64'(result0), 64'd0);
    check("abort_status", 64'({busy0, done0, cout0, ovf0, st0}), 64'd0);
    @(posedge clk); #1;
    issue(0, 32'd5, 32'd6, 32'h0000000B, 1'b0, 1'b0, 1'b1);
    wait_done(0);

    // full-width chunk: one busy cycle, start coincident with done accepted
    issue(1, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1, 1'b1);
    @(posedge clk); #1;
    check("dut1_done_before_b2b", 64'(done1), 64'd1);
    issue(1, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0, 1'b1);
    check("dut1_b2b_accepted", 64'({busy1, done1}), 64'b10);
    wait_done(1);

    repeat (2) @(posedge clk);
    check("q0_drained", 64'(exp_q0.size()), 64'd0);
    check("q1_drained", 64'(exp_q1.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
